// File: rtl/adpll_chan_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : adpll_chan_sched_if
// Description : Requester and controller-side signal bundle for the ADPLL
//               channel scheduler. The master side (requesters and ADPLL
//               controller) drives requests, channel words and channel_lock;
//               the slave side (scheduler) drives grants, status, FCW and mode.
// Revision    : 1.0 - initial release
// ============================================================================
interface adpll_chan_sched_if #(
    parameter int FCWW = 26
);
    logic            rx_req;
    logic [FCWW-1:0] rx_fcw;
    logic            rx_gnt;
    logic            tx_req;
    logic [FCWW-1:0] tx_fcw;
    logic            tx_gnt;
    logic            locked;
    logic            fail;
    logic            busy;
    logic [FCWW-1:0] FCW;
    logic [1:0]      adpll_mode;
    logic            channel_lock;

    modport master (
        output rx_req, rx_fcw, tx_req, tx_fcw, channel_lock,
        input  rx_gnt, tx_gnt, locked, fail, busy, FCW, adpll_mode
    );

    modport slave (
        input  rx_req, rx_fcw, tx_req, tx_fcw, channel_lock,
        output rx_gnt, tx_gnt, locked, fail, busy, FCW, adpll_mode
    );
endinterface
`default_nettype wire

// File: rtl/adpll_chan_sched.sv
`default_nettype none
// ============================================================================
// Module      : adpll_chan_sched
// Description : Channel scheduler in front of the ADPLL controller. Arbitrates
//               RX/TX requesters, latches the winner's FCW, waits for
//               channel_lock with a timeout and parks the controller in PD for
//               a guard interval after each release. State updates on the
//               falling edge of clk.
//               Optional macro ADPLL_SCHED_RR_EN: round-robin arbitration on
//               simultaneous requests (default: fixed TX-over-RX priority).
// Revision    : 1.0 - initial release
// ============================================================================
module adpll_chan_sched #(
    parameter int FCWW    = 26,
    parameter int LOCK_TO = 4095,
    parameter int GUARD   = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    adpll_chan_sched_if.slave     bus
);

    localparam logic [1:0]  c_mode_pd    = 2'd0;
    localparam logic [1:0]  c_mode_rx    = 2'd2;
    localparam logic [1:0]  c_mode_tx    = 2'd3;
    localparam logic [15:0] c_lock_to    = 16'(LOCK_TO);
    localparam logic [3:0]  c_guard_last = 4'(GUARD - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_LOCKED    = 3'd2,
        S_FAIL      = 3'd3,
        S_GUARD     = 3'd4
    } state_t;

    state_t          r_state;
    logic [15:0]     r_cnt;
    logic [3:0]      r_gcnt;
    logic            r_rx_gnt;
    logic            r_tx_gnt;
    logic            r_locked;
    logic            r_fail;
    logic            r_busy;
    logic [FCWW-1:0] r_fcw;
    logic [1:0]      r_mode;

    logic            w_any_req;
    logic            w_pick_tx;
    logic            w_owner_req;
    logic            w_release;

`ifdef ADPLL_SCHED_RR_EN
    // 1 = TX owned last; a tie goes to whichever side did not own last.
    logic            r_last_tx;
    assign w_pick_tx = bus.tx_req && (!bus.rx_req || !r_last_tx);
`else
    assign w_pick_tx = bus.tx_req;
`endif

    assign w_any_req   = bus.rx_req || bus.tx_req;
    assign w_owner_req = r_tx_gnt ? bus.tx_req : bus.rx_req;
    // Owner dropping its request outranks lock and timeout on the same edge.
    assign w_release   = !w_owner_req &&
                         ((r_state == S_WAIT_LOCK) || (r_state == S_LOCKED) ||
                          (r_state == S_FAIL));

    // Scheduler state machine with registered outputs, falling-edge clocked.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_gcnt   <= '0;
            r_rx_gnt <= 1'b0;
            r_tx_gnt <= 1'b0;
            r_locked <= 1'b0;
            r_fail   <= 1'b0;
            r_busy   <= 1'b0;
            r_fcw    <= '0;
            r_mode   <= c_mode_pd;
`ifdef ADPLL_SCHED_RR_EN
            r_last_tx <= 1'b1;
`endif
        end else if (en) begin
            if (w_release) begin
                // FCW is intentionally held so the controller sees a clean PD.
                r_rx_gnt <= 1'b0;
                r_tx_gnt <= 1'b0;
                r_locked <= 1'b0;
                r_fail   <= 1'b0;
                r_mode   <= c_mode_pd;
                r_gcnt   <= '0;
                r_state  <= S_GUARD;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_mode <= c_mode_pd;
                        if (w_any_req) begin
                            r_tx_gnt <= w_pick_tx;
                            r_rx_gnt <= !w_pick_tx;
                            r_fcw    <= w_pick_tx ? bus.tx_fcw : bus.rx_fcw;
                            r_mode   <= w_pick_tx ? c_mode_tx : c_mode_rx;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_WAIT_LOCK;
`ifdef ADPLL_SCHED_RR_EN
                            r_last_tx <= w_pick_tx;
`endif
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (bus.channel_lock) begin
                            r_locked <= 1'b1;
                            r_state  <= S_LOCKED;
                        end else if (r_cnt == c_lock_to) begin
                            r_fail  <= 1'b1;
                            r_mode  <= c_mode_pd;
                            r_state <= S_FAIL;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_LOCKED: begin
                        if (!bus.channel_lock) begin
                            r_locked <= 1'b0;
                            r_cnt    <= '0;
                            r_state  <= S_WAIT_LOCK;
                        end
                    end
                    S_FAIL: begin
                        r_state <= S_FAIL;
                    end
                    S_GUARD: begin
                        if (r_gcnt == c_guard_last) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_gcnt <= r_gcnt + 4'd1;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_mode  <= c_mode_pd;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rx_gnt     = r_rx_gnt;
    assign bus.tx_gnt     = r_tx_gnt;
    assign bus.locked     = r_locked;
    assign bus.fail       = r_fail;
    assign bus.busy       = r_busy;
    assign bus.FCW        = r_fcw;
    assign bus.adpll_mode = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_adpll_chan_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_adpll_chan_sched
// Description : Self-checking bench for adpll_chan_sched. Grants expected from
//               each request are queued and matched when a grant rises;
//               timing of lock, timeout, guard, enable and reset is checked
//               directly against edge counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adpll_chan_sched;

    localparam int FCWW    = 26;
    localparam int LOCK_TO = 100;
    localparam int GUARD   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;

    adpll_chan_sched_if #(.FCWW(FCWW)) bus ();

    adpll_chan_sched #(
        .FCWW    (FCWW),
        .LOCK_TO (LOCK_TO),
        .GUARD   (GUARD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            is_tx;
        logic [FCWW-1:0] fcw;
        logic [1:0]      mode;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_last_tx;
    logic prev_rx  = 1'b0;
    logic prev_tx  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
    endtask

    task automatic check_outs(input string tag, input logic rxg, input logic txg,
                              input logic lk, input logic fl, input logic bsy,
                              input logic [1:0] md);
        check({tag, "_rx_gnt"}, bus.rx_gnt, rxg);
        check({tag, "_tx_gnt"}, bus.tx_gnt, txg);
        check({tag, "_locked"}, bus.locked, lk);
        check({tag, "_fail"},   bus.fail,   fl);
        check({tag, "_busy"},   bus.busy,   bsy);
        check({tag, "_mode"},   bus.adpll_mode, md);
    endtask

    // Drive requests and queue the grant the arbitration rules predict.
    task automatic do_req(input logic rx, input logic tx, output logic win_tx);
        exp_t e;
`ifdef ADPLL_SCHED_RR_EN
        win_tx = tx && (!rx || !m_last_tx);
`else
        win_tx = tx;
`endif
        e.is_tx = win_tx;
        e.fcw   = win_tx ? bus.tx_fcw : bus.rx_fcw;
        e.mode  = win_tx ? 2'd3 : 2'd2;
        sb_q.push_back(e);
        m_last_tx  = win_tx;
        bus.rx_req = rx;
        bus.tx_req = tx;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!bus.busy) return;
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Grant monitor: pops the scoreboard on each new grant.
    always @(posedge clk) begin
        exp_t e;
        check("gnt_mutex", {31'd0, bus.rx_gnt & bus.tx_gnt}, 32'd0);
        if ((bus.rx_gnt && !prev_rx) || (bus.tx_gnt && !prev_tx)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_gnt", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_owner_tx", {31'd0, bus.tx_gnt}, {31'd0, e.is_tx});
                check("sb_fcw",  {6'd0, bus.FCW}, {6'd0, e.fcw});
                check("sb_mode", {30'd0, bus.adpll_mode}, {30'd0, e.mode});
            end
        end
        prev_rx = bus.rx_gnt;
        prev_tx = bus.tx_gnt;
    end

    initial begin
        logic w;
        m_last_tx        = 1'b1;
        bus.rx_req       = 1'b0;
        bus.tx_req       = 1'b0;
        bus.rx_fcw       = '0;
        bus.tx_fcw       = '0;
        bus.channel_lock = 1'b0;

        // Reset values
        tick(3);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("reset_fcw", {6'd0, bus.FCW}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single RX: grant, FCW latch, lock, release, guard
        bus.rx_fcw = 26'h0A0C000;
        do_req(1'b1, 1'b0, w);
        tick();
        check_outs("rx_grant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        check("rx_fcw", {6'd0, bus.FCW}, 32'h0A0C000);
        bus.rx_fcw = 26'h1234567;
        tick(40);
        check("fcw_hold", {6'd0, bus.FCW}, 32'h0A0C000);
        check("rx_not_locked", {31'd0, bus.locked}, 32'd0);
        bus.channel_lock = 1'b1;
        tick();
        check_outs("rx_locked", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        bus.rx_req       = 1'b0;
        bus.channel_lock = 1'b0;
        tick();
        check_outs("rx_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        check("release_fcw_held", {6'd0, bus.FCW}, 32'h0A0C000);

        // TX request arrives during the guard; it must wait for IDLE
        bus.tx_fcw = 26'h2BC0000;
        do_req(1'b0, 1'b1, w);
        for (int i = 1; i < GUARD; i++) begin
            tick();
            check("guard_busy",  {31'd0, bus.busy}, 32'd1);
            check("guard_mode",  {30'd0, bus.adpll_mode}, 32'd0);
            check("guard_tx_gnt", {31'd0, bus.tx_gnt}, 32'd0);
        end
        tick();
        check("guard_end_idle", {31'd0, bus.busy}, 32'd0);
        check("guard_end_tx_gnt", {31'd0, bus.tx_gnt}, 32'd0);

        // Timeout: no lock, fail at LOCK_TO+1 edges after grant
        tick();
        check_outs("tx_grant", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
        tick(LOCK_TO);
        check("pre_timeout_fail", {31'd0, bus.fail}, 32'd0);
        tick();
        check_outs("timeout", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
        tick(3);
        check("fail_level", {31'd0, bus.fail}, 32'd1);
        bus.tx_req = 1'b0;
        tick();
        check_outs("fail_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        wait_idle();

        // Lock on the timeout edge wins; then lock loss and re-timeout
        bus.rx_fcw = 26'h0B00000;
        do_req(1'b1, 1'b0, w);
        tick();
        check("ll_grant", {31'd0, bus.rx_gnt}, 32'd1);
        tick(LOCK_TO);
        bus.channel_lock = 1'b1;
        tick();
        check_outs("lock_at_to", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        bus.channel_lock = 1'b0;
        tick();
        check_outs("lock_lost", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        bus.channel_lock = 1'b1;
        tick();
        check_outs("relock", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        check("relock_fcw", {6'd0, bus.FCW}, 32'h0B00000);
        bus.channel_lock = 1'b0;
        tick();
        check("loss_unlocked", {31'd0, bus.locked}, 32'd0);
        tick(LOCK_TO);
        check("loss_pre_fail", {31'd0, bus.fail}, 32'd0);
        tick();
        check_outs("loss_timeout", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        bus.rx_req = 1'b0;
        wait_idle();

        // Enable low freezes the timeout counter and holds outputs
        bus.tx_fcw = 26'h3000001;
        do_req(1'b0, 1'b1, w);
        tick();
        check("en_grant", {31'd0, bus.tx_gnt}, 32'd1);
        tick(50);
        en = 1'b0;
        tick(20);
        check_outs("en_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
        en = 1'b1;
        tick(LOCK_TO - 50);
        check("en_pre_fail", {31'd0, bus.fail}, 32'd0);
        tick();
        check("en_fail", {31'd0, bus.fail}, 32'd1);
        bus.tx_req = 1'b0;
        wait_idle();

        // Release on the same edge as lock: release wins
        bus.rx_fcw = 26'h0C00000;
        do_req(1'b1, 1'b0, w);
        tick();
        check("abort_grant", {31'd0, bus.rx_gnt}, 32'd1);
        tick(5);
        bus.channel_lock = 1'b1;
        bus.rx_req       = 1'b0;
        tick();
        check_outs("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < GUARD; i++) begin
            tick();
            check("abort_never_locked", {31'd0, bus.locked}, 32'd0);
        end
        bus.channel_lock = 1'b0;
        wait_idle();

        // Contention: simultaneous requests, three rounds
        for (int r = 0; r < 3; r++) begin
            bus.rx_fcw = 26'h0D00000 + 26'(r);
            bus.tx_fcw = 26'h0E00000 + 26'(r);
            do_req(1'b1, 1'b1, w);
            tick();
            check("cont_tx_gnt", {31'd0, bus.tx_gnt}, {31'd0, w});
            bus.channel_lock = 1'b1;
            tick();
            check("cont_locked", {31'd0, bus.locked}, 32'd1);
            tick(3);
            check("cont_no_preempt", {31'd0, bus.tx_gnt}, {31'd0, w});
            bus.rx_req       = 1'b0;
            bus.tx_req       = 1'b0;
            bus.channel_lock = 1'b0;
            wait_idle();
        end

        // Asynchronous reset mid-LOCKED
        bus.rx_fcw = 26'h0F00000;
        do_req(1'b1, 1'b0, w);
        tick();
        bus.channel_lock = 1'b1;
        tick();
        check("prerst_locked", {31'd0, bus.locked}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("async_rst_fcw", {6'd0, bus.FCW}, 32'd0);
        bus.rx_req       = 1'b0;
        bus.channel_lock = 1'b0;
        m_last_tx        = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick();
        bus.tx_fcw = 26'h1000000;
        do_req(1'b0, 1'b1, w);
        tick();
        check_outs("post_rst_grant", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
        bus.tx_req = 1'b0;
        wait_idle();

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
